// File: rtl/alu_pkg.sv
// Shared ALU definitions: ALUOp encodings and the multiply sequencer state encoding.
// Used by the multiply sequencer and by anything that drives the shared ALU.
package alu_pkg;

    localparam int ALUOP_W = 4;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALUOP_W-1:0] ALU_AND = 4'b0010;
    localparam logic [ALUOP_W-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALUOP_W-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALUOP_W-1:0] ALU_SLL = 4'b0101;
    localparam logic [ALUOP_W-1:0] ALU_SRL = 4'b0110;
    localparam logic [ALUOP_W-1:0] ALU_NOR = 4'b0111;
    localparam logic [ALUOP_W-1:0] ALU_SLT = 4'b1000;
    localparam logic [ALUOP_W-1:0] ALU_SLE = 4'b1001;
    localparam logic [ALUOP_W-1:0] ALU_SEQ = 4'b1010;
    localparam logic [ALUOP_W-1:0] ALU_SNE = 4'b1011;
    localparam logic [ALUOP_W-1:0] ALU_SGT = 4'b1100;
    localparam logic [ALUOP_W-1:0] ALU_SGE = 4'b1101;
    localparam logic [ALUOP_W-1:0] ALU_SRA = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ADD  = 3'd1,
        ST_SHL  = 3'd2,
        ST_SHR  = 3'd3,
        ST_DONE = 3'd4
    } mul_state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/result and shared-ALU signal bundle for the multiply sequencer.
// Handshake: start is a pulse honoured only while busy=0; done pulses one cycle with result valid.
interface alu_mul_seq_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = ALUOP_W
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             alu_own;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [OP_W-1:0]  alu_op;
    logic [WIDTH-1:0] alu_out;
    mul_state_t       dbg_state;

    modport master (
        output start, op_a, op_b, alu_out,
        input  busy, done, result, alu_own, alu_a, alu_b, alu_op, dbg_state
    );

    modport slave (
        input  start, op_a, op_b, alu_out,
        output busy, done, result, alu_own, alu_a, alu_b, alu_op, dbg_state
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-add unsigned multiplier (low WIDTH bits) that borrows the shared ALU,
// issuing one ADD/SLL/SRL per cycle while it owns the ALU.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int OP_W  = ALUOP_W
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_mul_seq_if.slave bus
);

    mul_state_t       state, state_nxt;
    logic [WIDTH-1:0] acc, mcand, mplier, result_q;
    logic             own_c;
    logic [WIDTH-1:0] a_c, b_c;
    logic [OP_W-1:0]  op_c;

    always_comb begin
        state_nxt = state;
        own_c     = 1'b0;
        a_c       = '0;
        b_c       = '0;
        op_c      = '0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op_b == '0)    state_nxt = ST_DONE;
                    else if (bus.op_b[0]) state_nxt = ST_ADD;
                    else                   state_nxt = ST_SHL;
                end
            end
            ST_ADD: begin
                own_c     = 1'b1;
                a_c       = acc;
                b_c       = mcand;
                op_c      = ALU_ADD;
                state_nxt = ST_SHL;
            end
            ST_SHL: begin
                own_c     = 1'b1;
                a_c       = mcand;
                b_c       = WIDTH'(1);
                op_c      = ALU_SLL;
                state_nxt = ST_SHR;
            end
            ST_SHR: begin
                own_c = 1'b1;
                a_c   = mplier;
                b_c   = WIDTH'(1);
                op_c  = ALU_SRL;
                // Decide on the shifted multiplier the ALU is producing this cycle.
                if (bus.alu_out == '0)    state_nxt = ST_DONE;
                else if (bus.alu_out[0]) state_nxt = ST_ADD;
                else                      state_nxt = ST_SHL;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.op_a;
                        mplier <= bus.op_b;
                        acc    <= '0;
                    end
                end
                ST_ADD:  acc      <= bus.alu_out;
                ST_SHL:  mcand    <= bus.alu_out;
                ST_SHR:  mplier   <= bus.alu_out;
                ST_DONE: result_q <= acc;
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = (state == ST_DONE);
    assign bus.result    = (state == ST_DONE) ? acc : result_q;
    assign bus.alu_own   = own_c;
    assign bus.alu_a     = a_c;
    assign bus.alu_b     = b_c;
    assign bus.alu_op    = op_c;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed bench for alu_mul_seq with a behavioural shared ALU wired to the ALU bus.
module tb_alu_mul_seq;
    import alu_pkg::*;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   cyc;
    int   own_cnt;
    int   done_cnt;
    logic [3:0]  first_op;
    logic [31:0] first_a;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Behavioural stand-in for the shared ALU.
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_op)
            ALU_ADD: bus.alu_out = bus.alu_a + bus.alu_b;
            ALU_SUB: bus.alu_out = bus.alu_a - bus.alu_b;
            ALU_AND: bus.alu_out = bus.alu_a & bus.alu_b;
            ALU_OR:  bus.alu_out = bus.alu_a | bus.alu_b;
            ALU_XOR: bus.alu_out = bus.alu_a ^ bus.alu_b;
            ALU_SLL: bus.alu_out = bus.alu_a << bus.alu_b[4:0];
            ALU_SRL: bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
            ALU_NOR: bus.alu_out = ~(bus.alu_a | bus.alu_b);
            default: bus.alu_out = '0;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done after the accept edge; cyc counts cycles since that edge.
    task automatic wait_done();
        own_cnt = 0;
        while (!bus.done && cyc < 200) begin
            if (bus.alu_own) own_cnt++;
            tick();
            cyc++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_res, input int exp_lat);
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc       = 1;
        first_op  = bus.alu_op;
        first_a   = bus.alu_a;
        wait_done();
        check({tag, "_lat"}, cyc, exp_lat);
        check({tag, "_res"}, bus.result, exp_res);
        check({tag, "_own_cycles"}, own_cnt, exp_lat - 1);
        check({tag, "_own_at_done"}, {31'b0, bus.alu_own}, 32'd0);
        check({tag, "_op_at_done"}, {28'b0, bus.alu_op}, 32'd0);
        tick();
        check({tag, "_busy_after"}, {31'b0, bus.busy}, 32'd0);
        check({tag, "_done_after"}, {31'b0, bus.done}, 32'd0);
        check({tag, "_res_held"}, bus.result, exp_res);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_own", {31'b0, bus.alu_own}, 32'd0);
        check("rst_op", {28'b0, bus.alu_op}, 32'd0);
        check("rst_state", {29'b0, bus.dbg_state}, 32'd0);

        // 7 x 6: first op is SLL of the multiplicand since op_b[0]=0.
        run_mul("m7x6", 32'd7, 32'd6, 32'd42, 9);
        check("m7x6_first_op", {28'b0, first_op}, 32'h5);
        check("m7x6_first_a", first_a, 32'd7);

        // Multiplier zero: done right away, ALU never borrowed.
        run_mul("m5x0", 32'd5, 32'd0, 32'd0, 1);

        run_mul("m1x1", 32'd1, 32'd1, 32'd1, 4);
        check("m1x1_first_op", {28'b0, first_op}, 32'h0);

        run_mul("mffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 97);
        run_mul("m123x10", 32'd123, 32'd10, 32'd1230, 11);

        // start held high: re-accept only in the IDLE cycle after done.
        bus.op_a  = 32'h0001_0000;
        bus.op_b  = 32'h0001_0000;
        bus.start = 1'b1;
        tick();
        cyc = 1;
        wait_done();
        check("hold1_lat", cyc, 36);
        check("hold1_res", bus.result, 32'd0);
        tick();
        check("hold_idle_gap", {31'b0, bus.busy}, 32'd0);
        tick();
        bus.start = 1'b0;
        check("hold_reaccept", {31'b0, bus.busy}, 32'd1);
        cyc = 1;
        wait_done();
        check("hold2_lat", cyc, 36);
        check("hold2_res", bus.result, 32'd0);
        tick();

        // Mid-operation reset abandons the multiply.
        run_mul("pre7x6", 32'd7, 32'd6, 32'd42, 9);
        bus.op_a  = 32'd7;
        bus.op_b  = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        while (cyc < 4) begin
            tick();
            cyc++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_busy", {31'b0, bus.busy}, 32'd0);
        check("mrst_done", {31'b0, bus.done}, 32'd0);
        check("mrst_result", bus.result, 32'd0);
        check("mrst_own", {31'b0, bus.alu_own}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 120; i++) begin
            if (bus.done) done_cnt++;
            tick();
        end
        check("mrst_no_done", done_cnt, 0);
        run_mul("m3x3", 32'd3, 32'd3, 32'd9, 7);

        // start pulses while busy and in DONE are ignored.
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd5;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        cyc = 1;
        tick();
        cyc++;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'd9;
        bus.start = 1'b1;
        tick();
        cyc++;
        bus.start = 1'b0;
        wait_done();
        bus.start = 1'b1;
        check("ign_lat", cyc, 9);
        check("ign_res", bus.result, 32'd15);
        tick();
        bus.start = 1'b0;
        check("ign_idle", {31'b0, bus.busy}, 32'd0);
        tick();
        check("ign_still_idle", {31'b0, bus.busy}, 32'd0);
        check("ign_res_held", bus.result, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
